// File: rtl/pll_lock_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_seq
// Description : PLL lock qualifier and reset/clock-enable sequencer.
//               Synchronises the asynchronous PLL lock flag, waits for it to
//               stay high long enough, releases the peripheral reset, then
//               the CPU reset a fixed number of cycles later. It also
//               generates phase-aligned pixel and CPU clock-enable pulses
//               that start when the peripheral reset is released. Losing
//               lock returns everything to the reset state on the next edge.
//
// Ports       : clk           sequencer clock (PLL output)
//               rst           asynchronous active-high reset
//               pll_locked    PLL lock flag, asynchronous to clk
//               rst_periph    active-high reset for video/sound/peripherals
//               rst_cpu       active-high reset for CPU cores
//               ce_pix        one-cycle pixel enable pulse
//               ce_cpu        one-cycle CPU enable pulse (coincides with ce_pix)
//               ready         high once the sequence has reached RUN
//               lock_loss_cnt saturating count of lock losses after
//                             qualification (only with PLL_LOSS_COUNT_EN)
//
// Build macro : PLL_LOSS_COUNT_EN - adds the lock_loss_cnt output and counter.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int RST_STAGGER   = 16,
  parameter int CE_PIX_DIV    = 3,
  parameter int CE_CPU_DIV    = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       rst_periph,
  output logic       rst_cpu,
  output logic       ce_pix,
  output logic       ce_cpu,
`ifdef PLL_LOSS_COUNT_EN
  output logic [7:0] lock_loss_cnt,
`endif
  output logic       ready
);

  // Shared sequencing counter must hold values up to the larger bound.
  localparam int CNT_MAX = (STABLE_CYCLES > RST_STAGGER) ? STABLE_CYCLES : RST_STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PCNT_W  = ($clog2(CE_PIX_DIV) < 1) ? 1 : $clog2(CE_PIX_DIV);
  localparam int CCNT_W  = ($clog2(CE_CPU_DIV) < 1) ? 1 : $clog2(CE_CPU_DIV);

  localparam logic [CNT_W-1:0]  c_STABLE_END  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  c_STAGGER_END = CNT_W'(RST_STAGGER - 1);
  localparam logic [CNT_W-1:0]  c_CNT_ONE     = CNT_W'(1);
  localparam logic [PCNT_W-1:0] c_PIX_END     = PCNT_W'(CE_PIX_DIV - 1);
  localparam logic [PCNT_W-1:0] c_PIX_ONE     = PCNT_W'(1);
  localparam logic [CCNT_W-1:0] c_CPU_END     = CCNT_W'(CE_CPU_DIV - 1);
  localparam logic [CCNT_W-1:0] c_CPU_ONE     = CCNT_W'(1);

  localparam logic [1:0] c_ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] c_ST_STABLE    = 2'd1;
  localparam logic [1:0] c_ST_RELEASE   = 2'd2;
  localparam logic [1:0] c_ST_RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rst_periph;
  logic                   r_rst_cpu;
  logic                   r_ready;
  logic [PCNT_W-1:0]      r_pcnt;
  logic [CCNT_W-1:0]      r_ccnt;
  logic                   r_ce_pix;
  logic                   r_ce_cpu;

  logic w_lock_s;
  logic w_loss;

  assign w_lock_s = r_sync[SYNC_STAGES-1];
  // Any state past WAIT_LOCK falls back as soon as synchronised lock drops.
  assign w_loss   = !w_lock_s && (r_state != c_ST_WAIT_LOCK);

  // Lock flag synchroniser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Sequencing FSM and registered reset/ready outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_rst_periph <= 1'b1;
      r_rst_cpu    <= 1'b1;
      r_ready      <= 1'b0;
    end else if (w_loss) begin
      r_state      <= c_ST_WAIT_LOCK;
      r_cnt        <= '0;
      r_rst_periph <= 1'b1;
      r_rst_cpu    <= 1'b1;
      r_ready      <= 1'b0;
    end else begin
      case (r_state)
        c_ST_WAIT_LOCK: begin
          r_cnt <= '0;
          if (w_lock_s) begin
            r_state <= c_ST_STABLE;
          end
        end
        c_ST_STABLE: begin
          // r_cnt counts completed qualified cycles in STABLE; release
          // happens on the edge after STABLE_CYCLES of them have elapsed,
          // giving SYNC_STAGES+STABLE_CYCLES+1 edges from first lock sample.
          if (r_cnt == c_STABLE_END) begin
            r_state      <= c_ST_RELEASE;
            r_cnt        <= '0;
            r_rst_periph <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_ST_RELEASE: begin
          if (r_cnt == c_STAGGER_END) begin
            r_state   <= c_ST_RUN;
            r_cnt     <= '0;
            r_rst_cpu <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        c_ST_RUN: begin
          r_cnt <= '0;
        end
        default: begin
          r_state <= c_ST_WAIT_LOCK;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Clock-enable dividers. Both counters leave zero on the same edge, so
  // with CE_CPU_DIV a multiple of CE_PIX_DIV every ce_cpu lands on a ce_pix.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt   <= '0;
      r_ccnt   <= '0;
      r_ce_pix <= 1'b0;
      r_ce_cpu <= 1'b0;
    end else if (w_loss || r_rst_periph) begin
      r_pcnt   <= '0;
      r_ccnt   <= '0;
      r_ce_pix <= 1'b0;
      r_ce_cpu <= 1'b0;
    end else begin
      if (r_pcnt == c_PIX_END) begin
        r_pcnt   <= '0;
        r_ce_pix <= 1'b1;
      end else begin
        r_pcnt   <= r_pcnt + c_PIX_ONE;
        r_ce_pix <= 1'b0;
      end
      if (r_ccnt == c_CPU_END) begin
        r_ccnt   <= '0;
        r_ce_cpu <= 1'b1;
      end else begin
        r_ccnt   <= r_ccnt + c_CPU_ONE;
        r_ce_cpu <= 1'b0;
      end
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] r_loss_cnt;

  // Only losses after qualification (RELEASE/RUN) are counted; saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_loss_cnt <= 8'h00;
    end else if (w_loss && (r_state == c_ST_RELEASE || r_state == c_ST_RUN)
                 && (r_loss_cnt != 8'hFF)) begin
      r_loss_cnt <= r_loss_cnt + 8'h01;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

  assign rst_periph = r_rst_periph;
  assign rst_cpu    = r_rst_cpu;
  assign ce_pix     = r_ce_pix;
  assign ce_cpu     = r_ce_cpu;
  assign ready      = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_seq
// Description : Scoreboard bench for pll_lock_seq. Stimulus pushes the
//               expected output changes (edge number + output vector) into a
//               queue; a monitor pops and compares whenever outputs change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pll_locked = 1'b0;
  logic rst_periph, rst_cpu, ce_pix, ce_cpu, ready;
`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] lock_loss_cnt;
`endif

  pll_lock_seq #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .RST_STAGGER  (4),
    .CE_PIX_DIV   (3),
    .CE_CPU_DIV   (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .rst_periph   (rst_periph),
    .rst_cpu      (rst_cpu),
    .ce_pix       (ce_pix),
    .ce_cpu       (ce_cpu),
`ifdef PLL_LOSS_COUNT_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .ready        (ready)
  );

  always #5 clk = ~clk;

  // Edge counter: value N means the Nth rising edge has happened.
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    int         e;
    logic [4:0] v;
  } ev_t;

  ev_t        sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         mon_en  = 1'b1;
  logic [4:0] last_exp = 5'b11000;
  logic [4:0] last_obs = 5'b11000;

  wire [4:0] outs = {rst_periph, rst_cpu, ready, ce_pix, ce_cpu};

  // Expected outputs at edge e for a lock first sampled at edge e0
  // (STABLE_CYCLES=8, RST_STAGGER=4, SYNC_STAGES=2, dividers 3/6).
  function automatic logic [4:0] wave(int e0, int e);
    int   rel;
    logic rp, rc, rdy, cp, cc;
    rel = e - e0;
    rp  = (rel < 11);
    rc  = (rel < 15);
    rdy = (rel >= 15);
    cp  = (rel >= 14) && (((rel - 14) % 3) == 0);
    cc  = (rel >= 17) && (((rel - 17) % 6) == 0);
    return {rp, rc, rdy, cp, cc};
  endfunction

  task automatic exp_at(int e, logic [4:0] v);
    ev_t ev;
    if (v != last_exp) begin
      ev.e = e;
      ev.v = v;
      sb.push_back(ev);
      last_exp = v;
    end
  endtask

  task automatic gen(int e0, int from, int to);
    for (int e = from; e <= to; e++) exp_at(e, wave(e0, e));
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: samples 2 time units after each rising edge.
  always begin
    ev_t ex;
    @(posedge clk);
    #2;
    if (mon_en && (outs !== last_obs)) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change edge=%0d got=%b (rp,rc,rdy,cp,cc)", cyc, outs);
      end else begin
        ex = sb.pop_front();
        if (ex.e != cyc || ex.v !== outs) begin
          n_fail++;
          $display("FAIL output_event got edge=%0d val=%b, expected edge=%0d val=%b",
                   cyc, outs, ex.e, ex.v);
        end
      end
      last_obs = outs;
    end
  end

  int e0, e1, e2, e3;

  initial begin
    #1;
    rst        = 1'b1;
    pll_locked = 1'b1;

    // Reset holds all outputs at their reset values even with lock high.
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (outs !== 5'b11000) begin
        n_fail++;
        $display("FAIL reset_state got=%b expected=11000", outs);
      end
    end

    // Phase A: lock from reset, run, then lose lock in RUN.
    @(negedge clk);
    rst = 1'b0;
    e0  = cyc + 1;
    gen(e0, e0 + 1, e0 + 32);
    exp_at(e0 + 33, 5'b11000);
    wait_cyc(e0 + 30);
    pll_locked = 1'b0;          // sampled at e0+31, outputs reset at e0+33

    // Phase B: clean re-lock repeats the full sequence, then lose again.
    wait_cyc(e0 + 36);
    pll_locked = 1'b1;
    e1 = cyc + 1;
    gen(e1, e1 + 1, e1 + 22);
    exp_at(e1 + 23, 5'b11000);
    wait_cyc(e1 + 20);
    pll_locked = 1'b0;          // sampled at e1+21

    // Phase C: re-lock with a one-cycle drop inside STABLE; qualification
    // restarts from the re-lock sampling edge e2+7.
    wait_cyc(e1 + 26);
    pll_locked = 1'b1;
    e2 = cyc + 1;
    e3 = e2 + 7;
    gen(e3, e3 + 1, e3 + 24);
    wait_cyc(e2 + 5);
    pll_locked = 1'b0;          // sampled low at e2+6
    @(negedge clk);
    pll_locked = 1'b1;          // sampled high again at e2+7
    wait_cyc(e3 + 24);
    mon_en = 1'b0;

    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events pending=%0d next_edge=%0d next_val=%b",
               sb.size(), sb[0].e, sb[0].v);
    end

`ifdef PLL_LOSS_COUNT_EN
    // Two losses from RUN counted; the STABLE glitch is not.
    n_tests++;
    if (lock_loss_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL lock_loss_cnt got=%0d expected=2", lock_loss_cnt);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
